// File: rtl/seg_counter.sv
// Up/down/load counter with wrap or saturate mode, terminal-count pulse and a
// coherent lane snapshot held under a valid/ack handshake.
module seg_counter #(
   parameter int LANES    = 4,
   parameter int LANE_W   = 8,
   parameter bit SATURATE = 1'b0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic                      up,
   input  logic                      load,
   input  logic [LANES*LANE_W-1:0]   load_val,
   input  logic                      snap_req,
   input  logic                      snap_ack,
   output logic [LANES*LANE_W-1:0]   count,
   output logic [LANES*LANE_W-1:0]   lanes,
   output logic                      snap_valid,
   output logic                      snap_drop,
   output logic                      tc
);

   localparam int CNT_W = LANES * LANE_W;
   localparam logic [CNT_W-1:0] MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] ZERO = '0;
   localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic at_bound;
   logic take;

   // Next value for one enabled step; at a boundary either wrap or hold.
   function automatic logic [CNT_W-1:0] step_val(input logic [CNT_W-1:0] cur,
                                                 input logic             dir_up);
      logic [CNT_W-1:0] nxt;
      if (dir_up) begin
         if (cur == MAX) nxt = SATURATE ? MAX : ZERO;
         else            nxt = cur + ONE;
      end else begin
         if (cur == ZERO) nxt = SATURATE ? ZERO : MAX;
         else             nxt = cur - ONE;
      end
      return nxt;
   endfunction

   always_comb begin
      at_bound = up ? (count == MAX) : (count == ZERO);
      take     = snap_req & (~snap_valid | snap_ack);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count      <= '0;
         lanes      <= '0;
         snap_valid <= 1'b0;
         snap_drop  <= 1'b0;
         tc         <= 1'b0;
      end else begin
         tc <= ~load & en & at_bound;
         if (load)    count <= load_val;
         else if (en) count <= step_val(count, up);

         // Snapshot samples the pre-edge count, independent of load/en this cycle.
         if (take) begin
            lanes      <= count;
            snap_valid <= 1'b1;
         end else if (snap_ack & snap_valid) begin
            snap_valid <= 1'b0;
         end
         snap_drop <= snap_req & snap_valid & ~snap_ack;
      end
   end

endmodule

// File: tb/tb_seg_counter.sv
// Directed bench for seg_counter: a wrap-mode and a saturate-mode instance
// driven by the same stimulus, checked against hand-computed values.
module tb_seg_counter;

   logic        clk = 1'b0;
   logic        reset, en, up, load, snap_req, snap_ack;
   logic [31:0] load_val;
   logic [31:0] count, lanes, count_s, lanes_s;
   logic        snap_valid, snap_drop, tc, snap_valid_s, snap_drop_s, tc_s;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   seg_counter #(.LANES(4), .LANE_W(8), .SATURATE(1'b0)) dut (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
      .snap_req(snap_req), .snap_ack(snap_ack), .count(count), .lanes(lanes),
      .snap_valid(snap_valid), .snap_drop(snap_drop), .tc(tc));

   seg_counter #(.LANES(4), .LANE_W(8), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
      .snap_req(snap_req), .snap_ack(snap_ack), .count(count_s), .lanes(lanes_s),
      .snap_valid(snap_valid_s), .snap_drop(snap_drop_s), .tc(tc_s));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en = 0; up = 1; load = 0; load_val = '0; snap_req = 0; snap_ack = 0;
   endtask

   initial begin
      reset = 1; idle();
      #1;
      tick();
      chk("rst_count", count, 32'h0);
      chk("rst_lanes", lanes, 32'h0);
      chk("rst_valid", {31'b0, snap_valid}, 32'h0);
      chk("rst_tc", {31'b0, tc}, 32'h0);

      // 1. count 300 cycles, then snapshot
      reset = 0; en = 1; up = 1;
      repeat (300) tick();
      chk("t1_count", count, 32'h0000_012C);
      en = 0; snap_req = 1;
      tick();
      chk("t1_valid", {31'b0, snap_valid}, 32'h1);
      chk("t1_lanes", lanes, 32'h0000_012C);
      chk("t1_lane1", {24'b0, lanes[15:8]}, 32'h01);
      chk("t1_lane0", {24'b0, lanes[7:0]}, 32'h2C);
      snap_req = 0; snap_ack = 1;
      tick();
      chk("t1_ack_valid", {31'b0, snap_valid}, 32'h0);
      chk("t1_ack_lanes", lanes, 32'h0000_012C);
      snap_ack = 0;

      // 2. up-count across MAX
      load = 1; load_val = 32'hFFFF_FFFE;
      tick();
      chk("t2_load", count, 32'hFFFF_FFFE);
      load = 0; en = 1; up = 1;
      tick();
      chk("t2_c0", count, 32'hFFFF_FFFF);
      chk("t2_tc0", {31'b0, tc}, 32'h0);
      tick();
      chk("t2_c1", count, 32'h0);
      chk("t2_tc1", {31'b0, tc}, 32'h1);
      chk("t2_sat_c1", count_s, 32'hFFFF_FFFF);
      chk("t2_sat_tc1", {31'b0, tc_s}, 32'h1);
      tick();
      chk("t2_c2", count, 32'h1);
      chk("t2_tc2", {31'b0, tc}, 32'h0);
      chk("t2_sat_c2", count_s, 32'hFFFF_FFFF);
      chk("t2_sat_tc2", {31'b0, tc_s}, 32'h1);

      // 3. down-count across 0; load with en=1 suppresses tc
      load = 1; load_val = 32'h1; en = 1; up = 0;
      tick();
      chk("t3_load", count, 32'h1);
      chk("t3_load_tc", {31'b0, tc}, 32'h0);
      load = 0;
      tick();
      chk("t3_c0", count, 32'h0);
      chk("t3_tc0", {31'b0, tc}, 32'h0);
      tick();
      chk("t3_c1", count, 32'hFFFF_FFFF);
      chk("t3_tc1", {31'b0, tc}, 32'h1);
      chk("t3_sat_c1", count_s, 32'h0);
      chk("t3_sat_tc1", {31'b0, tc_s}, 32'h1);
      tick();
      chk("t3_c2", count, 32'hFFFF_FFFE);
      chk("t3_tc2", {31'b0, tc}, 32'h0);
      chk("t3_sat_c2", count_s, 32'h0);
      chk("t3_sat_tc2", {31'b0, tc_s}, 32'h1);

      // 4. snapshot pending: drop, then req+ack together
      idle(); load = 1; load_val = 32'd5;
      tick();
      load = 0; snap_req = 1;
      tick();
      chk("t4_valid", {31'b0, snap_valid}, 32'h1);
      chk("t4_lanes5", lanes, 32'd5);
      chk("t4_nodrop", {31'b0, snap_drop}, 32'h0);
      snap_req = 0; load = 1; load_val = 32'd9;
      tick();
      load = 0; snap_req = 1;
      tick();
      chk("t4_drop", {31'b0, snap_drop}, 32'h1);
      chk("t4_keep5", lanes, 32'd5);
      chk("t4_keepvalid", {31'b0, snap_valid}, 32'h1);
      snap_req = 0;
      tick();
      chk("t4_drop_end", {31'b0, snap_drop}, 32'h0);
      load = 1; load_val = 32'd12;
      tick();
      load = 0; snap_req = 1; snap_ack = 1;
      tick();
      chk("t4_lanes12", lanes, 32'd12);
      chk("t4_valid12", {31'b0, snap_valid}, 32'h1);
      chk("t4_nodrop12", {31'b0, snap_drop}, 32'h0);

      // 5. consume, stray ack, then load+en+req in one cycle
      snap_req = 0; snap_ack = 1;
      tick();
      chk("t5_clr", {31'b0, snap_valid}, 32'h0);
      tick();
      chk("t5_stray_ack", {31'b0, snap_valid}, 32'h0);
      chk("t5_stray_lanes", lanes, 32'd12);
      snap_ack = 0; load = 1; load_val = 32'd7;
      tick();
      load = 1; load_val = 32'h55; en = 1; up = 1; snap_req = 1;
      tick();
      chk("t5_count", count, 32'h55);
      chk("t5_lanes", lanes, 32'd7);
      chk("t5_tc", {31'b0, tc}, 32'h0);
      chk("t5_valid", {31'b0, snap_valid}, 32'h1);
      idle(); reset = 1;
      tick();
      chk("t5_rst_count", count, 32'h0);
      chk("t5_rst_lanes", lanes, 32'h0);
      chk("t5_rst_valid", {31'b0, snap_valid}, 32'h0);
      chk("t5_rst_drop", {31'b0, snap_drop}, 32'h0);
      chk("t5_rst_tc", {31'b0, tc}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
